riscv_retire_trace_monitor: RTL and testbench
=============================================

Name: riscv_retire_trace_monitor

Overview:
- Synthesizable retire-trace monitor attached to the RISCV_Processor retire port.
- Counts cycles and retired instructions.
- Buffers per-instruction trace records (PC, instr, rd, writeback data) in a parametrised FIFO for a drain consumer (bench or debug UART).
- Raises `done` on a halt instruction, a self-loop jump, or a cycle-budget timeout. This replaces fixed-time simulation stop and per-retire counting in benches.

Parameters:
- XLEN, 32, width of PC and register data.
- DEPTH, 16, trace FIFO entries; power of two, minimum 2.
- CNT_W, 32, width of cycle/instret counters.
- MAX_CYCLES, 1000, cycle budget before timeout; 0 disables timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  arm/run monitor; low in DONE re-arms.
- retire_valid  in  1  one instruction retires this cycle.
- retire_pc  in  XLEN  PC of retiring instruction.
- retire_instr  in  32  encoding of retiring instruction.
- retire_rd  in  5  destination register index.
- retire_rd_we  in  1  instruction writes rd.
- retire_rd_data  in  XLEN  value written to rd.
- trace_ready  in  1  consumer accepts head record.
- trace_valid  out  1  FIFO non-empty; head record valid.
- trace_pc  out  XLEN  head record PC.
- trace_instr  out  32  head record instruction.
- trace_rd  out  5  head record rd.
- trace_rd_we  out  1  head record write enable.
- trace_rd_data  out  XLEN  head record data.
- cycle_count  out  CNT_W  cycles spent in RUN.
- instret_count  out  CNT_W  instructions retired in RUN.
- drop_count  out  16  records lost to full FIFO; saturates at 0xFFFF.
- done  out  1  run finished.
- done_cause  out  2  0 none, 1 ECALL/EBREAK, 2 self-loop JAL, 3 timeout.

Behaviour:
- Reset (rst low, async): state IDLE; all counters 0; FIFO empty; trace_valid 0; done 0; done_cause 0; trace_* data outputs 0.
- FSM IDLE -> RUN: on enable=1. The transition cycle clears cycle_count, instret_count, drop_count and FIFO pointers. Retires in IDLE are ignored.
- RUN, per cycle:
  - cycle_count += 1.
  - On retire_valid: instret_count += 1 and push one record.
  - Counters wrap modulo 2^CNT_W.
- Halt detect, on a retire_valid cycle in RUN:
  - instr 0x00000073 or 0x00100073 -> cause 1.
  - instr 0x0000006F (jal x0,0) -> cause 2.
- Timeout: MAX_CYCLES != 0 and cycle_count == MAX_CYCLES-1 -> cause 3.
- Priority when several fire in one cycle: 1 > 2 > 3.
- The halting instruction is itself counted and pushed.
- RUN -> DONE: next edge after any cause fires; done=1 and done_cause registered together.
- DONE:
  - Counters frozen; retires ignored; FIFO continues to drain.
  - enable=0 -> IDLE. done and done_cause stay valid until IDLE exits to RUN.
- FIFO:
  - First-word-fall-through; trace_valid = !empty; trace_* show the head combinationally from the register array.
  - Pop when trace_valid & trace_ready.
  - Push latency 1: a record retired at cycle N is visible at cycle N+1.
- Full FIFO:
  - Push with simultaneous pop: both occur, no drop.
  - Push without pop: record dropped, drop_count += 1 (saturating).
- Empty FIFO with trace_ready high: no effect.
- Reset mid-RUN: immediate return to reset values; in-flight records discarded.

Optional Feature:
- Macro TRACE_OVERWRITE_EN.
- Defined: a push to a full FIFO without pop overwrites the oldest entry (head advances) and still increments drop_count. The FIFO always holds the newest DEPTH records.
- Undefined: the newest record is dropped as described above.

Decomposition:
- Package riscv_trace_pkg:
  - trace_rec_t struct (pc, instr, rd, rd_we, rd_data).
  - done_cause_e enum.
  - state_e enum (IDLE, RUN, DONE).
  - Constants INSTR_ECALL, INSTR_EBREAK, INSTR_SELF_JAL.
- Sub-module trace_fifo: parametrised FWFT synchronous FIFO of trace_rec_t with count, full, empty and the overwrite option.
- Top holds the FSM, counters and halt detection.

Test Plan:
- Reset, enable=1, retire ADDI at pc 0x0, 0x4, 0x8, then 0x00000073 at 0xC -> done=1, cause 1, instret_count=4; FIFO drains 4 records with PCs 0x0, 0x4, 0x8, 0xC in order.
- MAX_CYCLES=20, retire one instr every 3 cycles, no halt -> done rises after cycle_count reaches 20; cause 3; instret_count=7.
- DEPTH=4, trace_ready=0, retire 6 -> trace_valid=1 and drop_count=2.
  - Macro off: drained PCs are the first 4.
  - Macro on: drained PCs are the last 4.
- FIFO full with trace_ready=1 and retire_valid=1 in the same cycle -> drop_count stays 0; occupancy stays 4.
- Retire 0x0000006F and timeout in the same cycle -> cause 2.
- Assert rst low mid-RUN with 3 records queued -> trace_valid=0, counters 0, done=0. Re-enable -> fresh run starting from count 0.

Source files
------------

// File: rtl/riscv_trace_pkg.sv
// Shared types for the retire-trace monitor: trace record, FSM state,
// done causes and the halt encodings watched on the retire port.
package riscv_trace_pkg;

   localparam int TRACE_XLEN = 32;

   localparam logic [31:0] INSTR_ECALL    = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK   = 32'h0010_0073;
   localparam logic [31:0] INSTR_SELF_JAL = 32'h0000_006F;

   typedef struct packed {
      logic [TRACE_XLEN-1:0] pc;
      logic [31:0]           instr;
      logic [4:0]            rd;
      logic                  rd_we;
      logic [TRACE_XLEN-1:0] rd_data;
   } trace_rec_t;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'd0,
      CAUSE_HALT     = 2'd1,
      CAUSE_SELF_JAL = 2'd2,
      CAUSE_TIMEOUT  = 2'd3
   } done_cause_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO of trace records with synchronous clear.
// With TRACE_OVERWRITE_EN a push into a full FIFO evicts the oldest entry.
module trace_fifo
   import riscv_trace_pkg::*;
#(
   parameter type rec_t = trace_rec_t,
   parameter int  DEPTH = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic push,
   input  rec_t din,
   input  logic pop,
   output rec_t dout,
   output logic full,
   output logic empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   rec_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_pop;
   logic          do_push;
   logic          head_adv;

   assign empty  = count == '0;
   assign full   = count == FULL_CNT;
   assign do_pop = pop && !empty;
   assign dout   = mem[rd_ptr];

`ifdef TRACE_OVERWRITE_EN
   // When full, the write lands on the old head slot and the head moves on.
   assign do_push  = push;
   assign head_adv = do_pop || (push && full);
`else
   assign do_push  = push && (!full || do_pop);
   assign head_adv = do_pop;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (head_adv) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(head_adv);
      end
   end

endmodule

// File: rtl/riscv_retire_trace_monitor.sv
// Retire-port monitor: cycle/instret counters, halt/timeout detection and
// a trace FIFO for a drain consumer. Optional macro: TRACE_OVERWRITE_EN.
module riscv_retire_trace_monitor
   import riscv_trace_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int DEPTH      = 16,
   parameter int CNT_W      = 32,
   parameter int MAX_CYCLES = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             retire_valid,
   input  logic [XLEN-1:0]  retire_pc,
   input  logic [31:0]      retire_instr,
   input  logic [4:0]       retire_rd,
   input  logic             retire_rd_we,
   input  logic [XLEN-1:0]  retire_rd_data,
   input  logic             trace_ready,
   output logic             trace_valid,
   output logic [XLEN-1:0]  trace_pc,
   output logic [31:0]      trace_instr,
   output logic [4:0]       trace_rd,
   output logic             trace_rd_we,
   output logic [XLEN-1:0]  trace_rd_data,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instret_count,
   output logic [15:0]      drop_count,
   output logic             done,
   output logic [1:0]       done_cause
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic [4:0]      rd;
      logic            rd_we;
      logic [XLEN-1:0] rd_data;
   } rec_t;

   localparam logic [CNT_W-1:0] LAST_CYCLE =
      CNT_W'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);

   state_e      state;
   done_cause_e cause;
   done_cause_e cause_q;
   rec_t        rec_in;
   rec_t        head;
   logic        arm;
   logic        push;
   logic        pop;
   logic        drop;
   logic        fifo_full;
   logic        fifo_empty;
   logic        timeout;
   logic        is_halt;
   logic        is_jal;

   assign arm     = (state == S_IDLE) && enable;
   assign push    = (state == S_RUN) && retire_valid;
   assign pop     = !fifo_empty && trace_ready;
   assign drop    = push && fifo_full && !pop;
   assign timeout = (MAX_CYCLES != 0) && (cycle_count == LAST_CYCLE);
   assign is_halt = retire_valid && (retire_instr == INSTR_ECALL ||
                                     retire_instr == INSTR_EBREAK);
   assign is_jal  = retire_valid && (retire_instr == INSTR_SELF_JAL);

   always_comb begin
      cause = CAUSE_NONE;
      priority case (1'b1)
         is_halt: cause = CAUSE_HALT;
         is_jal:  cause = CAUSE_SELF_JAL;
         timeout: cause = CAUSE_TIMEOUT;
         default: cause = CAUSE_NONE;
      endcase
   end

   assign rec_in = '{pc: retire_pc, instr: retire_instr, rd: retire_rd,
                     rd_we: retire_rd_we, rd_data: retire_rd_data};

   trace_fifo #(
      .rec_t (rec_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (arm),
      .push  (push),
      .din   (rec_in),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign trace_valid   = !fifo_empty;
   assign trace_pc      = head.pc;
   assign trace_instr   = head.instr;
   assign trace_rd      = head.rd;
   assign trace_rd_we   = head.rd_we;
   assign trace_rd_data = head.rd_data;
   assign done_cause    = cause_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_IDLE;
         cycle_count   <= '0;
         instret_count <= '0;
         drop_count    <= '0;
         done          <= 1'b0;
         cause_q       <= CAUSE_NONE;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (enable) begin
                  state         <= S_RUN;
                  cycle_count   <= '0;
                  instret_count <= '0;
                  drop_count    <= '0;
                  done          <= 1'b0;
                  cause_q       <= CAUSE_NONE;
               end
            end
            S_RUN: begin
               cycle_count <= cycle_count + CNT_W'(1);
               if (retire_valid) instret_count <= instret_count + CNT_W'(1);
               if (drop && drop_count != 16'hFFFF)
                  drop_count <= drop_count + 16'd1;
               if (cause != CAUSE_NONE) begin
                  state   <= S_DONE;
                  done    <= 1'b1;
                  cause_q <= cause;
               end
            end
            S_DONE: begin
               if (!enable) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_retire_trace_monitor.sv
// Scoreboard bench for riscv_retire_trace_monitor (DEPTH=4, MAX_CYCLES=20);
// honours TRACE_OVERWRITE_EN when the build defines it.
module tb_riscv_retire_trace_monitor;

   localparam int DEPTH = 4;
   localparam int MAXC  = 20;
   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] JAL0   = 32'h0000_006F;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        retire_valid = 1'b0;
   logic [31:0] retire_pc = '0;
   logic [31:0] retire_instr = '0;
   logic [4:0]  retire_rd = '0;
   logic        retire_rd_we = 1'b0;
   logic [31:0] retire_rd_data = '0;
   logic        trace_ready = 1'b0;
   logic        trace_valid;
   logic [31:0] trace_pc;
   logic [31:0] trace_instr;
   logic [4:0]  trace_rd;
   logic        trace_rd_we;
   logic [31:0] trace_rd_data;
   logic [31:0] cycle_count;
   logic [31:0] instret_count;
   logic [15:0] drop_count;
   logic        done;
   logic [1:0]  done_cause;

   riscv_retire_trace_monitor #(
      .XLEN(32), .DEPTH(DEPTH), .CNT_W(32), .MAX_CYCLES(MAXC)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .retire_valid(retire_valid), .retire_pc(retire_pc),
      .retire_instr(retire_instr), .retire_rd(retire_rd),
      .retire_rd_we(retire_rd_we), .retire_rd_data(retire_rd_data),
      .trace_ready(trace_ready), .trace_valid(trace_valid),
      .trace_pc(trace_pc), .trace_instr(trace_instr),
      .trace_rd(trace_rd), .trace_rd_we(trace_rd_we),
      .trace_rd_data(trace_rd_data), .cycle_count(cycle_count),
      .instret_count(instret_count), .drop_count(drop_count),
      .done(done), .done_cause(done_cause)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] data;
   } rec_t;

   int checks = 0;
   int failures = 0;
   rec_t exp_q[$];
   logic [31:0] drained[$];

   // reference model: phase 0 idle, 1 running, 2 finished
   int          m_phase;
   logic [31:0] m_cyc;
   logic [31:0] m_ret;
   int          m_drop;
   logic        m_done;
   int          m_cause;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst) begin
      bit   popped;
      int   c;
      rec_t r;
      if (!rst) begin
         m_phase = 0; m_cyc = 0; m_ret = 0; m_drop = 0;
         m_done = 0; m_cause = 0;
         exp_q.delete();
      end else begin
         popped = trace_ready && exp_q.size() > 0;
         if (m_phase == 0) begin
            if (popped) void'(exp_q.pop_front());
            if (enable) begin
               m_phase = 1; m_cyc = 0; m_ret = 0; m_drop = 0;
               m_done = 0; m_cause = 0;
               exp_q.delete();
            end
         end else if (m_phase == 1) begin
            c = 0;
            if (retire_valid && (retire_instr == ECALL ||
                                 retire_instr == EBREAK)) c = 1;
            else if (retire_valid && retire_instr == JAL0) c = 2;
            else if (m_cyc == MAXC - 1) c = 3;
            if (popped) void'(exp_q.pop_front());
            m_cyc = m_cyc + 1;
            if (retire_valid) begin
               m_ret = m_ret + 1;
               r.pc = retire_pc; r.instr = retire_instr;
               r.rd = retire_rd; r.we = retire_rd_we;
               r.data = retire_rd_data;
               if (exp_q.size() < DEPTH) exp_q.push_back(r);
               else begin
                  if (m_drop < 65535) m_drop++;
`ifdef TRACE_OVERWRITE_EN
                  void'(exp_q.pop_front());
                  exp_q.push_back(r);
`endif
               end
            end
            if (c != 0) begin
               m_phase = 2; m_done = 1; m_cause = c;
            end
         end else begin
            if (popped) void'(exp_q.pop_front());
            if (!enable) m_phase = 0;
         end
      end
   end

   always @(negedge clk) begin
      chk("trace_valid", trace_valid, exp_q.size() != 0);
      chk("cycle_count", cycle_count, m_cyc);
      chk("instret_count", instret_count, m_ret);
      chk("drop_count", drop_count, m_drop);
      chk("done", done, m_done);
      chk("done_cause", done_cause, m_cause);
      if (trace_valid && trace_ready && exp_q.size() > 0) begin
         chk("head_pc", trace_pc, exp_q[0].pc);
         chk("head_instr", trace_instr, exp_q[0].instr);
         chk("head_rd", trace_rd, exp_q[0].rd);
         chk("head_we", trace_rd_we, exp_q[0].we);
         chk("head_data", trace_rd_data, exp_q[0].data);
         drained.push_back(trace_pc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_alu();
      logic [31:0] v;
      v = $urandom;
      return {v[31:7], 7'h13};
   endfunction

   task automatic retire1(input logic [31:0] pc, input logic [31:0] instr);
      retire_valid   = 1'b1;
      retire_pc      = pc;
      retire_instr   = instr;
      retire_rd      = 5'($urandom);
      retire_rd_we   = 1'($urandom);
      retire_rd_data = $urandom;
      tick();
      retire_valid = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      for (int i = 0; i < bound && !done; i++) tick();
      chk("wait_done", done, 1'b1);
   endtask

   task automatic drain(input int n);
      drained.delete();
      trace_ready = 1'b1;
      repeat (n) tick();
      trace_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] base;
      logic [31:0] r;
      repeat (2) tick();
      chk("rst_valid", trace_valid, 1'b0);
      chk("rst_cycle", cycle_count, 0);
      chk("rst_instret", instret_count, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_done", done, 1'b0);
      chk("rst_cause", done_cause, 0);
      chk("rst_pc", trace_pc, 0);
      chk("rst_data", trace_rd_data, 0);
      rst = 1'b1;
      tick();

      // halt on ECALL after three ALU ops
      enable = 1'b1;
      tick();
      retire1(32'h0, 32'h0010_0093);
      retire1(32'h4, 32'h0020_0113);
      retire1(32'h8, 32'h0030_0193);
      retire1(32'hC, ECALL);
      chk("A_done", done, 1'b1);
      chk("A_cause", done_cause, 1);
      chk("A_instret", instret_count, 4);
      chk("A_cycle", cycle_count, 4);
      repeat (3) tick();
      chk("A_frozen", cycle_count, 4);
      drain(6);
      chk("A_n", drained.size(), 4);
      for (int i = 0; i < 4; i++) chk("A_pc", drained[i], 32'(4 * i));
      enable = 1'b0;
      tick();
      chk("A_idle_done", done, 1'b1);
      chk("A_idle_cause", done_cause, 1);

      // timeout with a retire every third cycle
      trace_ready = 1'b1;
      enable = 1'b1;
      tick();
      chk("B_cleared", done, 1'b0);
      for (int k = 0; k < 30; k++) begin
         if (k % 3 == 0) retire1(32'(4 * k), rand_alu());
         else tick();
      end
      chk("B_done", done, 1'b1);
      chk("B_cause", done_cause, 3);
      chk("B_cycle", cycle_count, 20);
      chk("B_instret", instret_count, 7);
      enable = 1'b0;
      trace_ready = 1'b0;
      tick();

      // overflow: six retires into four slots
      enable = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) retire1(32'h100 + 32'(4 * i), rand_alu());
      tick();
      chk("C_valid", trace_valid, 1'b1);
      chk("C_drop", drop_count, 2);
      drain(6);
      chk("C_n", drained.size(), 4);
`ifdef TRACE_OVERWRITE_EN
      base = 32'h108;
`else
      base = 32'h100;
`endif
      for (int i = 0; i < 4; i++) chk("C_pc", drained[i], base + 32'(4 * i));
      wait_done(30);
      enable = 1'b0;
      tick();

      // full FIFO with push and pop together
      enable = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) retire1(32'h200 + 32'(4 * i), rand_alu());
      drained.delete();
      trace_ready = 1'b1;
      retire1(32'h210, rand_alu());
      trace_ready = 1'b0;
      chk("D_drop", drop_count, 0);
      chk("D_popped", drained.size(), 1);
      drain(6);
      chk("D_occupancy", drained.size(), 4);
      chk("D_first", drained[0], 32'h204);
      chk("D_last", drained[3], 32'h210);
      wait_done(30);
      enable = 1'b0;
      tick();

      // self-loop JAL in the timeout cycle
      enable = 1'b1;
      tick();
      repeat (19) tick();
      retire1(32'h300, JAL0);
      chk("E_cause", done_cause, 2);
      chk("E_cycle", cycle_count, 20);
      chk("E_instret", instret_count, 1);
      enable = 1'b0;
      tick();

      // reset in the middle of a run
      enable = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) retire1(32'h400 + 32'(4 * i), rand_alu());
      chk("F_queued", trace_valid, 1'b1);
      #1 rst = 1'b0;
      #1;
      chk("F_valid", trace_valid, 1'b0);
      chk("F_cycle", cycle_count, 0);
      chk("F_instret", instret_count, 0);
      chk("F_done", done, 1'b0);
      #1 rst = 1'b1;
      tick();
      chk("F_fresh0", cycle_count, 0);
      tick();
      chk("F_fresh1", cycle_count, 1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         enable = ($urandom % 10) != 0;
         trace_ready = ($urandom % 10) < 6;
         retire_valid = 1'($urandom);
         retire_pc = $urandom;
         r = $urandom % 60;
         retire_instr = (r == 0) ? ECALL : (r == 1) ? EBREAK :
                        (r == 2) ? JAL0 : rand_alu();
         retire_rd = 5'($urandom);
         retire_rd_we = 1'($urandom);
         retire_rd_data = $urandom;
         tick();
      end
      retire_valid = 1'b0;
      enable = 1'b0;
      trace_ready = 1'b1;
      repeat (10) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
